// File: rtl/mode_pkg.sv
`default_nettype none
// ============================================================================
// Package : mode_pkg
// Brief   : Shared mode constants, press-FSM encoding and parameter defaults.
// Rev     : 1.0 - initial release
// ============================================================================
package mode_pkg;

   localparam logic [2:0] MODE_OFF = 3'd0;
   localparam logic [2:0] MODE_MAX = 3'd5;

   localparam int unsigned c_debounce_cycles_def = 4;
   localparam int unsigned c_long_cycles_def     = 16;
   localparam int unsigned c_tick_base_def       = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DB_PRESS   = 3'd1,
      PRESSED    = 3'd2,
      LONG       = 3'd3,
      DB_RELEASE = 3'd4
   } state_t;

   // Short-press advance: 0..5 cycling back to off.
   function automatic logic [2:0] next_mode(input logic [2:0] m);
      return (m == MODE_MAX) ? MODE_OFF : m + 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
// Module : step_timer
// Brief  : Paces the pattern datapath; period is TICK_BASE*mode cycles.
// Rev    : 1.0 - initial release
// ============================================================================
module step_timer
   import mode_pkg::*;
#(
   parameter int unsigned TICK_BASE = c_tick_base_def
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] mode,
   input  logic       clear,
   output logic       step_tick
);

   localparam logic [15:0] c_base = 16'(TICK_BASE);

   logic [15:0] r_cnt;
   logic [15:0] w_limit;
   logic        w_run;

   assign w_limit   = (c_base * {13'd0, mode}) - 16'd1;
   assign w_run     = (mode != MODE_OFF) && !clear;
   assign step_tick = w_run && (r_cnt == w_limit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 16'd0;
      end else if (!w_run || (r_cnt == w_limit)) begin
         r_cnt <= 16'd0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mode_sequencer
// Brief  : Debounced single-button mode selector (short = advance, long = off).
// Rev    : 1.0 - initial release
// ============================================================================
module mode_sequencer
   import mode_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_def,
   parameter int unsigned LONG_CYCLES     = c_long_cycles_def,
   parameter int unsigned TICK_BASE       = c_tick_base_def
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   output logic [2:0] mode,
   output logic [2:0] prev_mode,
   output logic       check,
   output logic       flick,
   output logic       mode_chg,
   output logic       step_tick,
   output logic       busy
);

   localparam logic [7:0]  c_db_last   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] c_hold_last = 16'(LONG_CYCLES - 1);

   logic        r_sync1;
   logic        r_sync2;
   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_db_cnt;
   logic [7:0]  w_db_cnt_nxt;
   logic [15:0] r_hold_cnt;
   logic [15:0] w_hold_cnt_nxt;
   logic        r_long_flag;
   logic        w_long_flag_nxt;
   logic        w_short_fire;
   logic        w_long_fire;
   logic [2:0]  r_mode;
   logic [2:0]  r_prev_mode;
   logic        r_check;
   logic        r_flick;
   logic        r_mode_chg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_db_cnt    <= 8'd0;
         r_hold_cnt  <= 16'd0;
         r_long_flag <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_db_cnt    <= w_db_cnt_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_long_flag <= w_long_flag_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_db_cnt_nxt    = r_db_cnt;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_long_flag_nxt = r_long_flag;
      w_short_fire    = 1'b0;
      w_long_fire     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_sync2) begin
               w_state_nxt  = DB_PRESS;
               w_db_cnt_nxt = 8'd0;
            end
         end
         DB_PRESS: begin
            if (!r_sync2) begin
               w_state_nxt = IDLE;
            end else if (r_db_cnt == c_db_last) begin
               w_state_nxt    = PRESSED;
               w_hold_cnt_nxt = 16'd0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + 8'd1;
            end
         end
         PRESSED: begin
            if (!r_sync2) begin
               w_state_nxt     = DB_RELEASE;
               w_db_cnt_nxt    = 8'd0;
               w_long_flag_nxt = 1'b0;
            end else if (r_hold_cnt == c_hold_last) begin
               // The long action is tied to this single transition, so it fires once per press.
               w_state_nxt = LONG;
               w_long_fire = 1'b1;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + 16'd1;
            end
         end
         LONG: begin
            if (!r_sync2) begin
               w_state_nxt     = DB_RELEASE;
               w_db_cnt_nxt    = 8'd0;
               w_long_flag_nxt = 1'b1;
            end
         end
         DB_RELEASE: begin
            if (r_sync2) begin
               w_db_cnt_nxt = 8'd0;
            end else if (r_db_cnt == c_db_last) begin
               w_state_nxt  = IDLE;
               w_short_fire = !r_long_flag;
            end else begin
               w_db_cnt_nxt = r_db_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode      <= MODE_OFF;
         r_prev_mode <= MODE_OFF;
         r_check     <= 1'b0;
         r_flick     <= 1'b0;
         r_mode_chg  <= 1'b0;
      end else begin
         r_check    <= w_short_fire;
         r_flick    <= w_long_fire;
         r_mode_chg <= 1'b0;
         if (w_short_fire) begin
            r_prev_mode <= r_mode;
            r_mode      <= next_mode(r_mode);
            r_mode_chg  <= 1'b1;
         end else if (w_long_fire) begin
            r_prev_mode <= r_mode;
            r_mode      <= MODE_OFF;
            r_mode_chg  <= (r_mode != MODE_OFF);
         end
      end
   end

   step_timer #(
      .TICK_BASE (TICK_BASE)
   ) u_step_timer (
      .clk       (clk),
      .rst       (rst),
      .mode      (r_mode),
      .clear     (r_mode_chg),
      .step_tick (step_tick)
   );

   assign mode      = r_mode;
   assign prev_mode = r_prev_mode;
   assign check     = r_check;
   assign flick     = r_flick;
   assign mode_chg  = r_mode_chg;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mode_sequencer
// Brief  : Directed self-checking bench for mode_sequencer at default parameters.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mode_sequencer;

   logic       clk;
   logic       rst;
   logic       btn;
   logic [2:0] mode;
   logic [2:0] prev_mode;
   logic       check;
   logic       flick;
   logic       mode_chg;
   logic       step_tick;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int n_check = 0;
   int n_flick = 0;
   int n_chg = 0;
   int n_tick = 0;
   int n_overlap = 0;
   int last_check_cyc = 0;
   int last_flick_cyc = 0;
   int chg_cyc = 0;
   int first_tick = -1;
   int last_tick = 0;
   int prev_tick = 0;

   mode_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .mode      (mode),
      .prev_mode (prev_mode),
      .check     (check),
      .flick     (flick),
      .mode_chg  (mode_chg),
      .step_tick (step_tick),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse bookkeeping, sampled mid-cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (check) begin
         n_check = n_check + 1;
         last_check_cyc = cyc;
      end
      if (flick) begin
         n_flick = n_flick + 1;
         last_flick_cyc = cyc;
      end
      if (check && flick) n_overlap = n_overlap + 1;
      if (mode_chg) begin
         n_chg = n_chg + 1;
         chg_cyc = cyc;
         first_tick = -1;
      end
      if (step_tick) begin
         n_tick = n_tick + 1;
         if (first_tick < 0) first_tick = cyc;
         prev_tick = last_tick;
         last_tick = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      btn = 1'b0;
      wait_cyc(3);
      rst = 1'b1;
      wait_cyc(2);
   endtask

   task automatic press(input int hold, input int gap);
      btn = 1'b1;
      wait_cyc(hold);
      btn = 1'b0;
      wait_cyc(gap);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      btn = 1'b0;
      wait_cyc(3);
      checks++;
      if ({mode, prev_mode} !== 6'd0) begin
         errors++;
         $display("FAIL reset_modes: got mode=%0d prev=%0d expected 0 0", mode, prev_mode);
      end
      checks++;
      if ({check, flick, mode_chg, step_tick, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_pulses: got %b expected 00000", {check, flick, mode_chg, step_tick, busy});
      end
      rst = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_short_press();
      int c0, g0, rel, seen;
      do_reset();
      c0 = n_check;
      g0 = n_chg;
      btn = 1'b1;
      wait_cyc(10);
      btn = 1'b0;
      rel = cyc;
      seen = 0;
      for (int i = 0; i < 8 && seen == 0; i++) begin
         wait_cyc(1);
         if (n_check != c0) seen = 1;
      end
      checks++;
      if (seen != 1 || (last_check_cyc - rel) > 8) begin
         errors++;
         $display("FAIL short_latency: got seen=%0d delay=%0d expected check within 8 cycles", seen, last_check_cyc - rel);
      end
      wait_cyc(12);
      checks++;
      if (n_check - c0 != 1) begin
         errors++;
         $display("FAIL short_check_count: got %0d expected 1", n_check - c0);
      end
      checks++;
      if (mode !== 3'd1 || prev_mode !== 3'd0) begin
         errors++;
         $display("FAIL short_mode: got mode=%0d prev=%0d expected 1 0", mode, prev_mode);
      end
      checks++;
      if (n_chg - g0 != 1) begin
         errors++;
         $display("FAIL short_mode_chg: got %0d expected 1", n_chg - g0);
      end
   endtask

   task automatic test_six_presses();
      logic [2:0] exp_mode [6];
      int g0;
      exp_mode = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
      do_reset();
      g0 = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) g0 = n_chg;
         press(8, 12);
         checks++;
         if (mode !== exp_mode[i]) begin
            errors++;
            $display("FAIL six_mode_%0d: got %0d expected %0d", i, mode, exp_mode[i]);
         end
      end
      checks++;
      if (prev_mode !== 3'd5 || n_chg - g0 != 1) begin
         errors++;
         $display("FAIL six_wrap: got prev=%0d chg=%0d expected 5 1", prev_mode, n_chg - g0);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] pat;
      logic [2:0] m0;
      int c0, f0;
      pat = 8'b1010_1110;
      m0 = mode;
      c0 = n_check;
      f0 = n_flick;
      for (int i = 7; i >= 0; i--) begin
         btn = pat[i];
         wait_cyc(1);
      end
      wait_cyc(20);
      checks++;
      if (n_check != c0 || n_flick != f0 || mode !== m0) begin
         errors++;
         $display("FAIL glitch_no_action: got checks=%0d flicks=%0d mode=%0d expected 0 0 %0d",
                  n_check - c0, n_flick - f0, mode, m0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_long_press();
      int c0, f0, g0, s0;
      do_reset();
      for (int i = 0; i < 3; i++) press(8, 12);
      c0 = n_check;
      f0 = n_flick;
      g0 = n_chg;
      s0 = cyc;
      press(40, 20);
      checks++;
      if (n_flick - f0 != 1 || n_check != c0) begin
         errors++;
         $display("FAIL long_pulses: got flicks=%0d checks=%0d expected 1 0", n_flick - f0, n_check - c0);
      end
      checks++;
      if ((last_flick_cyc - s0) < 20 || (last_flick_cyc - s0) > 26) begin
         errors++;
         $display("FAIL long_latency: got %0d expected 20..26", last_flick_cyc - s0);
      end
      checks++;
      if (mode !== 3'd0 || prev_mode !== 3'd3 || n_chg - g0 != 1) begin
         errors++;
         $display("FAIL long_mode: got mode=%0d prev=%0d chg=%0d expected 0 3 1", mode, prev_mode, n_chg - g0);
      end
      f0 = n_flick;
      g0 = n_chg;
      c0 = n_check;
      press(40, 20);
      checks++;
      if (n_flick - f0 != 1 || n_chg != g0 || n_check != c0) begin
         errors++;
         $display("FAIL long_at_off: got flicks=%0d chg=%0d checks=%0d expected 1 0 0",
                  n_flick - f0, n_chg - g0, n_check - c0);
      end
      checks++;
      if (mode !== 3'd0 || prev_mode !== 3'd0) begin
         errors++;
         $display("FAIL long_at_off_mode: got mode=%0d prev=%0d expected 0 0", mode, prev_mode);
      end
      checks++;
      if (n_overlap != 0) begin
         errors++;
         $display("FAIL check_flick_overlap: got %0d expected 0", n_overlap);
      end
   endtask

   task automatic test_step_tick();
      int t0;
      do_reset();
      press(8, 12);
      press(8, 40);
      checks++;
      if (mode !== 3'd2 || first_tick - chg_cyc != 16) begin
         errors++;
         $display("FAIL tick_first: got mode=%0d delay=%0d expected 2 16", mode, first_tick - chg_cyc);
      end
      t0 = n_tick;
      wait_cyc(64);
      checks++;
      if (n_tick - t0 != 4 || last_tick - prev_tick != 16) begin
         errors++;
         $display("FAIL tick_period: got count=%0d gap=%0d expected 4 16", n_tick - t0, last_tick - prev_tick);
      end
      press(30, 20);
      t0 = n_tick;
      wait_cyc(200);
      checks++;
      if (mode !== 3'd0 || n_tick != t0) begin
         errors++;
         $display("FAIL tick_off: got mode=%0d ticks=%0d expected 0 0", mode, n_tick - t0);
      end
   endtask

   task automatic test_reset_mid_press();
      int c0, f0;
      do_reset();
      for (int i = 0; i < 4; i++) press(8, 12);
      btn = 1'b1;
      wait_cyc(10);
      checks++;
      if (mode !== 3'd4 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midpress_setup: got mode=%0d busy=%b expected 4 1", mode, busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({mode, prev_mode, check, flick, mode_chg, step_tick, busy} !== 11'd0) begin
         errors++;
         $display("FAIL midpress_async_reset: got mode=%0d prev=%0d pulses=%b expected all 0",
                  mode, prev_mode, {check, flick, mode_chg, step_tick, busy});
      end
      wait_cyc(3);
      c0 = n_check;
      f0 = n_flick;
      rst = 1'b1;
      wait_cyc(3);
      btn = 1'b0;
      wait_cyc(20);
      checks++;
      if (n_check != c0 || n_flick != f0 || mode !== 3'd0) begin
         errors++;
         $display("FAIL midpress_discard: got checks=%0d flicks=%0d mode=%0d expected 0 0 0",
                  n_check - c0, n_flick - f0, mode);
      end
      press(8, 12);
      checks++;
      if (n_check - c0 != 1 || mode !== 3'd1 || prev_mode !== 3'd0) begin
         errors++;
         $display("FAIL midpress_fresh: got checks=%0d mode=%0d prev=%0d expected 1 1 0",
                  n_check - c0, mode, prev_mode);
      end
   endtask

   initial begin
      rst = 1'b0;
      btn = 1'b0;
      test_reset();
      test_short_press();
      test_six_presses();
      test_glitch();
      test_long_press();
      test_step_tick();
      test_reset_mid_press();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples needed to accept a button edge (range 2..255).
REQ-002 Parameter LONG_CYCLES, default 16, is the debounced hold length that makes a press "long" (range DEBOUNCE_CYCLES+1..65535).
REQ-003 Parameter TICK_BASE, default 8, is the step period unit; TICK_BASE*5 SHALL fit in 16 bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 btn  input  1  raw, asynchronous, bouncy push button (1 = pressed).
REQ-007 mode  output  3  current mode, 0..5 (0 = off).
REQ-008 prev_mode  output  3  mode held before the most recent mode action.
REQ-009 check  output  1  one-cycle pulse on each short-press advance.
REQ-010 flick  output  1  one-cycle pulse on each long-press action.
REQ-011 mode_chg  output  1  one-cycle pulse in the cycle mode takes a new value.
REQ-012 step_tick  output  1  one-cycle pulse that paces the pattern datapath for the current mode.
REQ-013 busy  output  1  high whenever the press FSM is not IDLE.

Function
REQ-014 btn SHALL pass through a 2-flop synchronizer; the FSM sees only the synchronized value s.
REQ-015 FSM states: IDLE, DB_PRESS, PRESSED, LONG, DB_RELEASE.
REQ-016 IDLE: s=1 -> DB_PRESS, debounce counter cleared.
REQ-017 DB_PRESS: s=0 -> IDLE with no action; DEBOUNCE_CYCLES consecutive s=1 samples -> PRESSED, hold counter cleared.
REQ-018 PRESSED: the hold counter increments each cycle; s=0 -> DB_RELEASE with long_flag=0; hold counter reaching LONG_CYCLES -> LONG.
REQ-019 Entry to LONG SHALL fire the long action exactly once, however long the button is then held.
REQ-020 LONG: s=0 -> DB_RELEASE with long_flag=1.
REQ-021 DB_RELEASE: any s=1 sample restarts the debounce count. DEBOUNCE_CYCLES consecutive s=0 samples -> IDLE. If long_flag=0, this transition fires the short action.
REQ-022 Short action: prev_mode<=mode; mode<=(mode==5)?0:mode+1; check=1.
REQ-023 Long action: prev_mode<=mode; mode<=0; flick=1.
REQ-024 Action outputs SHALL be registered and appear one cycle after the triggering FSM transition.
REQ-025 mode_chg SHALL pulse together with an action only if the mode value differs. A long action at mode 0 gives flick=1, mode_chg=0, and prev_mode<=0.
REQ-026 Step timer: a 16-bit counter, cleared on every mode_chg and held at 0 while mode==0.
REQ-027 Step timer, mode k>0: step_tick pulses when the counter equals TICK_BASE*k-1, and the counter wraps to 0 in the same cycle.
REQ-028 No step_tick SHALL occur in the cycle of mode_chg or in mode 0.
REQ-029 check and flick SHALL never be high in the same cycle; at most one action SHALL occur per press.

Reset
REQ-030 While rst=0, all outputs SHALL be 0: mode=0, prev_mode=0, pulses low, busy=0.
REQ-031 While rst=0, the FSM SHALL be in IDLE and all counters and synchronizer flops SHALL be 0.
REQ-032 Reset mid-press SHALL discard the press. After release of rst with btn held, a fresh debounce from IDLE SHALL be required.

Structure
REQ-033 Package mode_pkg SHALL hold MODE_OFF=3'd0, MODE_MAX=3'd5, the FSM state encoding, and the parameter defaults.
REQ-034 The step timer SHALL be a sub-module step_timer (inputs mode, clear; output step_tick). The FSM, synchronizer and mode register stay in mode_sequencer.

Verification (defaults DEBOUNCE_CYCLES=4, LONG_CYCLES=16, TICK_BASE=8)
REQ-035 Clean press held 10 cycles, then released -> exactly one check, mode 0->1, prev_mode=0, mode_chg=1, within 8 cycles of release.
REQ-036 Six clean short presses from reset -> mode 1,2,3,4,5,0; the sixth gives prev_mode=5 and mode_chg=1.
REQ-037 Press with 1-cycle glitches (1,0,1,0) before a 3-cycle high, then 0 -> no action; mode unchanged; busy returns to 0.
REQ-038 From mode 3, hold 40 cycles -> one flick about 22 cycles after press, mode=0, prev_mode=3, no check on release. Repeat at mode 0 -> flick=1, mode_chg=0.
REQ-039 Mode 2 steady -> step_tick every 16 cycles, first tick 16 cycles after mode_chg. Mode 0 -> no ticks over 200 cycles.
REQ-040 rst=0 pulse during PRESSED at mode 4 -> all outputs 0 immediately. rst=1 with btn still high -> no action until release plus a new debounced press.
